// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-read-port integer register file with a sequential clear
// engine (stack-pointer preset) and a per-register pending scoreboard.
// Optional build macro: REGFILE_BYPASS_EN. When it is defined, reads are
// write-first and return the same-cycle write data. Otherwise reads are
// read-first.
module reg_file_mp #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int SP_IDX = 2,
    parameter logic [XLEN-1:0] SP_INIT = 'h000003FC,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [XLEN-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0] rd_data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   pend_set,
    input  logic [AW-1:0]          pend_addr,
    input  logic                   clr_req,
    output logic                   ready
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_RUN   = 2'b01
    } state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     idx_reg, idx_next;
    logic [DEPTH-1:0]  pend_reg, pend_next;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem [DEPTH];

    logic              run;

    assign run   = (state_reg == ST_RUN);
    assign ready = run;

    // State, sweep index and pending bits; async reset restarts the sweep at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_CLEAR;
            idx_reg   <= AW'(1);
            pend_reg  <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            pend_reg  <= pend_next;
        end
    end

    // Next-state logic and the single array write port (sweep or user write).
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        pend_next  = pend_reg;
        mem_we     = 1'b0;
        mem_waddr  = idx_reg;
        mem_wdata  = '0;
        case (state_reg)
            ST_CLEAR: begin
                // Index 0 is never stored; reads of it are forced to zero.
                mem_we    = 1'b1;
                mem_waddr = idx_reg;
                mem_wdata = (idx_reg == AW'(SP_IDX)) ? SP_INIT : '0;
                if (idx_reg == AW'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                    idx_next   = AW'(1);
                end else begin
                    idx_next = idx_reg + AW'(1);
                end
            end
            ST_RUN: begin
                if (clr_req) begin
                    // Re-clear takes priority; same-cycle write/set are dropped.
                    state_next = ST_CLEAR;
                    idx_next   = AW'(1);
                    pend_next  = '0;
                end else begin
                    if (wr_en && (wr_addr != '0)) begin
                        mem_we    = 1'b1;
                        mem_waddr = wr_addr;
                        mem_wdata = wr_data;
                    end
                    if (wr_en) begin
                        pend_next[wr_addr] = 1'b0;
                    end
                    // Applied after the clear so a new producer wins on the same index.
                    if (pend_set && (pend_addr != '0)) begin
                        pend_next[pend_addr] = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_CLEAR;
                idx_next   = AW'(1);
                pend_next  = '0;
            end
        endcase
        pend_next[0] = 1'b0;
    end

    // Register array: no reset, written by the sweep or the write port.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Combinational read ports; all outputs held at zero while clearing.
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0]   ra;
            logic [XLEN-1:0] stored;
            assign ra     = rd_addr[gi*AW +: AW];
            assign stored = (ra == '0) ? '0 : mem[ra];
`ifdef REGFILE_BYPASS_EN
            logic hit;
            assign hit = run && wr_en && !clr_req && (wr_addr != '0) && (wr_addr == ra);
            assign rd_data[gi*XLEN +: XLEN] = !run ? '0 : (hit ? wr_data : stored);
            assign rd_busy[gi] = !run ? 1'b0 :
                                 (hit ? (pend_set && (pend_addr == ra)) : pend_reg[ra]);
`else
            assign rd_data[gi*XLEN +: XLEN] = run ? stored : '0;
            assign rd_busy[gi] = run && pend_reg[ra];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench for reg_file_mp. Each stimulus cycle pushes
// the expected outputs from an array-level reference model. A negedge monitor
// pops and compares them.
module tb_reg_file_mp;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;
    localparam int SP     = 2;
    localparam logic [31:0] SPV = 32'h000003FC;

    logic                   clk;
    logic                   rst_n;
    logic                   wr_en;
    logic [AW-1:0]          wr_addr;
    logic [XLEN-1:0]        wr_data;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   pend_set;
    logic [AW-1:0]          pend_addr;
    logic                   clr_req;
    logic                   ready;

    reg_file_mp #(
        .XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .SP_IDX(SP), .SP_INIT(SPV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .pend_set(pend_set), .pend_addr(pend_addr),
        .clr_req(clr_req), .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        int          step;
        logic        rdy;
        logic [63:0] data;
        logic [1:0]  busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    // Reference model: register contents, pending set, and cycles left until ready.
    logic [31:0] m_mem [DEPTH];
    logic        m_pend [DEPTH];
    int          m_left;

    task automatic cyc(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic ps, input logic [4:0] pa,
                       input logic cr, input logic [4:0] a0, input logic [4:0] a1);
        exp_t        e;
        logic [4:0]  ra;
        @(posedge clk);
        #1;
        rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd;
        pend_set = ps; pend_addr = pa; clr_req = cr; rd_addr = {a1, a0};
        if (!r) begin
            m_left = DEPTH - 1;
            for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
        end
        e.step = step_no;
        e.rdy  = (m_left == 0);
        e.data = '0;
        e.busy = '0;
        for (int k = 0; k < 2; k++) begin
            ra = (k == 0) ? a0 : a1;
            if (e.rdy) begin
                e.data[k*32 +: 32] = (ra == 0) ? 32'h0 : m_mem[ra];
                e.busy[k]          = m_pend[ra];
`ifdef REGFILE_BYPASS_EN
                if (we && !cr && wa != 0 && wa == ra) begin
                    e.data[k*32 +: 32] = wd;
                    e.busy[k]          = ps && (pa == ra);
                end
`endif
            end
        end
        exp_q.push_back(e);
        step_no++;
        // Effect of the coming rising edge.
        if (r) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
                    m_mem[SP] = SPV;
                end
            end else if (cr) begin
                m_left = DEPTH - 1;
                for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
            end else begin
                if (we && wa != 0) m_mem[wa] = wd;
                if (we) m_pend[wa] = 1'b0;
                if (ps && pa != 0) m_pend[pa] = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n, input logic [4:0] a0, input logic [4:0] a1);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, a0, a1);
    endtask

    // Monitor: compare each presented cycle against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (ready !== e.rdy) begin
                    failures++;
                    $display("FAIL ready step %0d got %b exp %b", e.step, ready, e.rdy);
                end
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (rd_data[k*32 +: 32] !== e.data[k*32 +: 32]) begin
                        failures++;
                        $display("FAIL rd_data%0d step %0d got %h exp %h", k, e.step,
                                 rd_data[k*32 +: 32], e.data[k*32 +: 32]);
                    end
                    checks++;
                    if (rd_busy[k] !== e.busy[k]) begin
                        failures++;
                        $display("FAIL rd_busy%0d step %0d got %b exp %b", k, e.step,
                                 rd_busy[k], e.busy[k]);
                    end
                end
                $display("step %0d rdy=%b d0=%h d1=%h busy=%b", e.step, ready,
                         rd_data[31:0], rd_data[63:32], rd_busy);
            end
        end
    end

    initial begin : stimulus
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        pend_set = 1'b0; pend_addr = '0; clr_req = 1'b0; rd_addr = '0;
        m_left = DEPTH - 1;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = 32'h0;
            m_pend[i] = 1'b0;
        end
        // Reset, then the full sweep observed on x2 / x5.
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd2, 5'd5);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd2, 5'd5);
        // Writes and pend_set during the sweep must be ignored.
        cyc(1'b1, 1'b1, 5'd5, 32'h11111111, 1'b1, 5'd5, 1'b0, 5'd2, 5'd5);
        idle(DEPTH + 1, 5'd2, 5'd5);
        // Normal write, then a discarded write to x0.
        cyc(1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
        cyc(1'b1, 1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 1'b0, 5'd7, 5'd0);
        idle(1, 5'd7, 5'd0);
        // Same-cycle write and read of x9.
        cyc(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9);
        idle(1, 5'd9, 5'd9);
        // Pending scoreboard on x4.
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd1);
        idle(1, 5'd4, 5'd1);
        cyc(1'b1, 1'b1, 5'd4, 32'h00000040, 1'b0, 5'd0, 1'b0, 5'd4, 5'd4);
        idle(1, 5'd4, 5'd4);
        cyc(1'b1, 1'b1, 5'd4, 32'h00000044, 1'b1, 5'd4, 1'b0, 5'd4, 5'd4);
        idle(1, 5'd4, 5'd4);
        // Set one index while writing another.
        cyc(1'b1, 1'b1, 5'd4, 32'h00000045, 1'b1, 5'd6, 1'b0, 5'd4, 5'd6);
        idle(1, 5'd4, 5'd6);
        // Re-clear with a same-cycle write of x3, plus clr_req during the sweep.
        cyc(1'b1, 1'b1, 5'd3, 32'h5, 1'b1, 5'd3, 1'b1, 5'd3, 5'd2);
        idle(5, 5'd3, 5'd2);
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd3, 5'd2);
        idle(DEPTH, 5'd3, 5'd2);
        // Reset pulse mid-sweep at idx=10.
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd2, 5'd7);
        idle(9, 5'd2, 5'd7);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd2, 5'd7);
        idle(DEPTH + 1, 5'd2, 5'd7);
        // Randomized traffic concentrated on a few indices to force collisions.
        for (int n = 0; n < 500; n++) begin
            logic        we, ps, cr;
            logic [4:0]  wa, pa, a0, a1;
            we = ($urandom_range(0, 1) == 1);
            ps = ($urandom_range(0, 3) == 0);
            cr = ($urandom_range(0, 99) == 0);
            wa = 5'($urandom_range(0, 7));
            pa = 5'($urandom_range(0, 7));
            a0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 7));
            cyc(1'b1, we, wa, $urandom, ps, pa, cr, a0, a1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
